// File: rtl/i2c_master_controller.sv
// ---------------------------------------------------------------------------
// i2c_master_controller
// Single-byte I2C master: START, 7-bit address + R/W, address ACK, one data
// byte (write or read), data ACK/NACK, STOP. SCL is push-pull and derived
// from clk by a quarter-period divider; SDA is open-drain (0 or released).
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   start    - command strobe, sampled only in IDLE
//   addr     - 7-bit target address, captured with start
//   rw       - 0 = master write, 1 = master read, captured with start
//   data_in  - byte to write, captured with start
//   data_out - byte read from the slave (only updated on a clean read)
//   busy     - high from the cycle after an accepted start until done
//   done     - one-clk pulse when IDLE is re-entered
//   ack_err  - slave NACK seen in the last transaction
//   i2c_scl  - SCL, push-pull
//   i2c_sda  - SDA, open-drain
// ---------------------------------------------------------------------------
module i2c_master_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       i2c_scl,
  inout  wire        i2c_sda
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ZERO = DW'(0);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_ADDR      = 4'd2,
    S_ADDR_ACK  = 4'd3,
    S_WRITE     = 4'd4,
    S_WRITE_ACK = 4'd5,
    S_READ      = 4'd6,
    S_READ_ACK  = 4'd7,
    S_STOP      = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    phase_q, phase_d;     // 0..3 = A,B,C,D
  logic [2:0]    bit_q, bit_d;         // bit index, counts down, wraps 0->7
  logic [7:0]    abyte_q, abyte_d;     // {addr, rw}
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rd_sr_q, rd_sr_d;
  logic          samp_q, samp_d;       // SDA sampled at the end of phase C
  logic [7:0]    data_out_q, data_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic          tick_s;
  logic          sda_in_s;

  assign tick_s   = (div_q == DIV_LAST);
  assign sda_in_s = i2c_sda;

  // SCL level for a given state/phase: high while idle and through START,
  // otherwise low in A,B and high in C,D.
  function automatic logic scl_for(input state_e s, input logic [1:0] ph);
    logic lvl;
    case (s)
      S_IDLE, S_START: lvl = 1'b1;
      default:         lvl = ph[1];
    endcase
    return lvl;
  endfunction

  // Whether the master pulls SDA low for a given state/phase/bit.
  function automatic logic sda_low_for(input state_e s, input logic [1:0] ph,
                                       input logic [2:0] b, input logic [7:0] ab,
                                       input logic [7:0] wd);
    logic low;
    case (s)
      S_START: low = ph[1];             // falling SDA in C while SCL high
      S_ADDR:  low = ~ab[b];
      S_WRITE: low = ~wd[b];
      S_STOP:  low = (ph != 2'd3);      // rising SDA in D while SCL high
      default: low = 1'b0;
    endcase
    return low;
  endfunction

  // Next-state logic: divider, phase/bit sequencing, sampling and outputs.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    abyte_d    = abyte_q;
    wdata_d    = wdata_q;
    rd_sr_d    = rd_sr_q;
    samp_d     = samp_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    ack_err_d  = ack_err_q;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      div_d   = DIV_ZERO;
      phase_d = 2'd0;
      bit_d   = 3'd0;
      if (start) begin
        state_d   = S_START;
        abyte_d   = {addr, rw};
        wdata_d   = data_in;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
      end else begin
        busy_d    = 1'b0;
      end
    end else if (!tick_s) begin
      div_d = div_q + DIV_ONE;
    end else begin
      div_d   = DIV_ZERO;
      phase_d = phase_q + 2'd1;
      case (phase_q)
        2'd2: begin
          samp_d = sda_in_s;
          if (state_q == S_READ) begin
            rd_sr_d = {rd_sr_q[6:0], sda_in_s};
          end else begin
            rd_sr_d = rd_sr_q;
          end
        end
        2'd3: begin
          // End of a bit period: state transitions happen only here.
          case (state_q)
            S_START: begin
              state_d = S_ADDR;
              bit_d   = bit_q - 3'd1;
            end
            S_ADDR: begin
              if (bit_q == 3'd0) begin
                state_d = S_ADDR_ACK;
              end else begin
                bit_d = bit_q - 3'd1;
              end
            end
            S_ADDR_ACK: begin
              if (samp_q) begin
                ack_err_d = 1'b1;
                state_d   = S_STOP;
              end else begin
                state_d = abyte_q[0] ? S_READ : S_WRITE;
                bit_d   = bit_q - 3'd1;
              end
            end
            S_WRITE: begin
              if (bit_q == 3'd0) begin
                state_d = S_WRITE_ACK;
              end else begin
                bit_d = bit_q - 3'd1;
              end
            end
            S_WRITE_ACK: begin
              if (samp_q) begin
                ack_err_d = 1'b1;
              end else begin
                ack_err_d = ack_err_q;
              end
              state_d = S_STOP;
            end
            S_READ: begin
              if (bit_q == 3'd0) begin
                state_d = S_READ_ACK;
              end else begin
                bit_d = bit_q - 3'd1;
              end
            end
            S_READ_ACK: begin
              if (!ack_err_q) begin
                data_out_d = rd_sr_q;
              end else begin
                data_out_d = data_out_q;
              end
              state_d = S_STOP;
            end
            S_STOP: begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          endcase
        end
        default: begin
          samp_d = samp_q;
        end
      endcase
    end

    // Outputs are registered from the next state so SCL/SDA change exactly
    // at the start of each phase.
    scl_d     = scl_for(state_d, phase_d);
    sda_low_d = sda_low_for(state_d, phase_d, bit_d, abyte_d, wdata_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= DIV_ZERO;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      abyte_q    <= 8'h00;
      wdata_q    <= 8'h00;
      rd_sr_q    <= 8'h00;
      samp_q     <= 1'b0;
      data_out_q <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      abyte_q    <= abyte_d;
      wdata_q    <= wdata_d;
      rd_sr_q    <= rd_sr_d;
      samp_q     <= samp_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign i2c_scl  = scl_q;
  assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_controller
// Scoreboard bench: each command pushes its expected completion (data_out,
// ack_err, latency) and any byte the slave should receive; a monitor pops
// and compares on done, a behavioural slave (address 7'h2A, read data 0xCC)
// compares received bytes, and a bus watcher checks SCL widths and counts
// START/STOP conditions.
// ---------------------------------------------------------------------------
module tb_i2c_master_controller;

  localparam int CLK_DIV  = 4;
  localparam int LAT_FULL = 80 * CLK_DIV;
  localparam int LAT_NACK = 44 * CLK_DIV;
  localparam logic [6:0] SLV_ADDR = 7'h2A;
  localparam logic [7:0] SLV_TX   = 8'hCC;

  typedef struct packed {
    logic [7:0]  dout;
    logic        err;
    logic [31:0] lat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       i2c_scl;
  wire        i2c_sda;
  logic       slv_low;
  logic       sda_s;

  pullup (i2c_sda);
  assign i2c_sda = slv_low ? 1'b0 : 1'bz;
  assign sda_s   = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;

  i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .addr     (addr),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .i2c_scl  (i2c_scl),
    .i2c_sda  (i2c_sda)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_start_seen = 0;
  int   n_stop_seen  = 0;
  int   n_start_exp  = 0;
  int   n_stop_exp   = 0;
  exp_t       exp_q[$];
  logic [7:0] slv_exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] d, input logic e, input int l);
    exp_t x;
    x.dout = d;
    x.err  = e;
    x.lat  = l;
    return x;
  endfunction

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    exp_t e;
    int   acc_cyc;
    logic busy_prev;
    acc_cyc   = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy && !busy_prev) acc_cyc = cyc;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("data_out", data_out, e.dout);
            check("ack_err", ack_err, e.err);
            check("latency", cyc - acc_cyc, e.lat);
            check("busy_at_done", busy, 1'b0);
            check("scl_idle", i2c_scl, 1'b1);
            check("sda_idle", sda_s, 1'b1);
          end
        end
        busy_prev = busy;
      end
    end
  end

  // Bus watcher: SCL high/low widths and START/STOP counting.
  initial begin : proto
    logic ps, pd, run_ok, saw_start;
    int   run;
    ps = 1'b1; pd = 1'b1; run_ok = 1'b0; saw_start = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps = 1'b1; pd = 1'b1; run_ok = 1'b0; saw_start = 1'b0; run = 0;
      end else begin
        if (ps && i2c_scl && (pd != sda_s)) begin
          if (!sda_s) begin
            n_start_seen++;
            saw_start = 1'b1;
          end else begin
            n_stop_seen++;
          end
        end
        if (ps != i2c_scl) begin
          // The high run spanning STOP/IDLE/START is not a bit half-period.
          if (run_ok && !(ps && saw_start))
            check(ps ? "scl_high_width" : "scl_low_width", run, 2 * CLK_DIV);
          run       = 1;
          run_ok    = 1'b1;
          saw_start = 1'b0;
        end else begin
          run++;
        end
        ps = i2c_scl;
        pd = sda_s;
      end
    end
  end

  // Behavioural slave at SLV_ADDR; mode 0 idle, 1 addr, 2 addr ack,
  // 3 write data, 4 write ack, 5 read data, 6 master ack.
  initial begin : slave
    logic       ps, pd, rwb;
    logic [7:0] sr;
    logic [7:0] tx;
    int         mode, cnt;
    ps = 1'b1; pd = 1'b1; rwb = 1'b0; sr = 8'h00; tx = SLV_TX; mode = 0; cnt = 0;
    slv_low = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mode = 0; slv_low = 1'b0; ps = 1'b1; pd = 1'b1;
      end else begin
        if (ps && i2c_scl && pd && !sda_s) begin
          mode = 1; cnt = 0; sr = 8'h00; slv_low = 1'b0;
        end else if (ps && i2c_scl && !pd && sda_s) begin
          mode = 0; slv_low = 1'b0;
        end else if (!ps && i2c_scl) begin
          case (mode)
            1, 3: begin sr = {sr[6:0], sda_s}; cnt++; end
            5:    cnt++;
            6:    begin check("master_nack", sda_s, 1'b1); mode = 0; end
            default: ;
          endcase
        end else if (ps && !i2c_scl) begin
          case (mode)
            1: if (cnt == 8) begin
                 if (sr[7:1] == SLV_ADDR) begin
                   slv_low = 1'b1; rwb = sr[0]; mode = 2;
                 end else begin
                   mode = 0;
                 end
               end
            2: begin
                 cnt = 0; sr = 8'h00;
                 if (rwb) begin mode = 5; slv_low = ~tx[7]; end
                 else begin mode = 3; slv_low = 1'b0; end
               end
            3: if (cnt == 8) begin
                 if (slv_exp_q.size() == 0) begin
                   n_checks++;
                   n_fail++;
                   $display("FAIL unexpected_slave_byte: got 0x%0h, expected none", sr);
                 end else begin
                   check("slave_byte", sr, slv_exp_q.pop_front());
                 end
                 slv_low = 1'b1; mode = 4;
               end
            4: begin slv_low = 1'b0; mode = 0; end
            5: if (cnt == 8) begin slv_low = 1'b0; mode = 6; end
               else slv_low = ~tx[7 - cnt];
            default: ;
          endcase
        end
        ps = i2c_scl;
        pd = sda_s;
      end
    end
  end

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    addr = a; rw = r; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no done, expected done within 4000 cycles", name);
    end
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got busy=0, expected busy within 100 cycles", name);
    end
  endtask

  initial begin : stim
    rst_n = 1'b0; start = 1'b0; addr = 7'h00; rw = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl", i2c_scl, 1'b1);
    check("rst_sda", sda_s, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    rst_n = 1'b1;

    // Write 0x5A to the slave.
    exp_q.push_back(mk_exp(8'h00, 1'b0, LAT_FULL));
    slv_exp_q.push_back(8'h5A);
    n_start_exp++; n_stop_exp++;
    issue(SLV_ADDR, 1'b0, 8'h5A);
    wait_done("write_5a");

    // Read 0xCC from the slave.
    exp_q.push_back(mk_exp(8'hCC, 1'b0, LAT_FULL));
    n_start_exp++; n_stop_exp++;
    issue(SLV_ADDR, 1'b1, 8'h00);
    wait_done("read_cc");

    // Address nobody answers: NACK path, data_out keeps 0xCC.
    exp_q.push_back(mk_exp(8'hCC, 1'b1, LAT_NACK));
    n_start_exp++; n_stop_exp++;
    issue(7'h15, 1'b0, 8'h77);
    wait_done("addr_nack");

    // Mid-transfer start pulse with different command must be ignored.
    exp_q.push_back(mk_exp(8'hCC, 1'b0, LAT_FULL));
    slv_exp_q.push_back(8'h99);
    n_start_exp++; n_stop_exp++;
    issue(SLV_ADDR, 1'b0, 8'h99);
    repeat (100) @(negedge clk);
    addr = 7'h15; rw = 1'b1; data_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid_pulse");

    // Start held high: two back-to-back writes, 0x11 then 0x22.
    exp_q.push_back(mk_exp(8'hCC, 1'b0, LAT_FULL));
    exp_q.push_back(mk_exp(8'hCC, 1'b0, LAT_FULL));
    slv_exp_q.push_back(8'h11);
    slv_exp_q.push_back(8'h22);
    n_start_exp += 2; n_stop_exp += 2;
    @(negedge clk);
    addr = SLV_ADDR; rw = 1'b0; data_in = 8'h11; start = 1'b1;
    wait_busy("b2b_accept1");
    data_in = 8'h22;
    wait_done("b2b_first");
    wait_busy("b2b_accept2");
    start = 1'b0;
    wait_done("b2b_second");

    // Reset during the fourth data bit of a write (SCL low).
    n_start_exp++;
    issue(SLV_ADDR, 1'b0, 8'hA5);
    repeat (212) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_scl", i2c_scl, 1'b1);
    check("abort_sda", sda_s, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ack_err", ack_err, 1'b0);
    check("abort_data_out", data_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Normal write after the abort.
    exp_q.push_back(mk_exp(8'h00, 1'b0, LAT_FULL));
    slv_exp_q.push_back(8'h3C);
    n_start_exp++; n_stop_exp++;
    issue(SLV_ADDR, 1'b0, 8'h3C);
    wait_done("write_after_reset");

    repeat (10) @(negedge clk);
    check("pending_completions", exp_q.size(), 0);
    check("pending_slave_bytes", slv_exp_q.size(), 0);
    check("start_count", n_start_seen, n_start_exp);
    check("stop_count", n_stop_seen, n_stop_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
Single-byte I2C master that generates START, a 7-bit address plus R/W, one data byte (write or read), ACK handling and STOP on the shared SCL/SDA bus. It sits directly upstream of the team's I2C slave controller (address 7'b0101010) and is driven by a local host through a start/done command interface. SCL is derived from the system clock by a quarter-period divider.

Parameters:
CLK_DIV, 4, system clocks per SCL quarter-period (>=2); one bit period = 4*CLK_DIV clocks

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
addr  input  7  target slave address
rw  input  1  0 = master write, 1 = master read
data_in  input  8  byte to write, captured with start
data_out  output  8  byte read from slave
busy  output  1  high from accepted start until done
done  output  1  one-clk pulse at end of transaction
ack_err  output  1  slave NACK seen in last transaction
i2c_scl  output  1  SCL, push-pull
i2c_sda  inout  1  SDA, open-drain: driven 0 or released to z

Behaviour:
- Reset (async, rst_n=0): state IDLE, i2c_scl=1, SDA released, busy=0, done=0, ack_err=0, data_out=8'h00, counters 0. Reset mid-transfer aborts immediately with the same values; no STOP is generated.
- Command: in IDLE with start=1 at a clk edge, capture addr, rw, data_in; clear ack_err; busy=1 from the next cycle. start is ignored while busy.
- Bit timing: each bit = 4 phases (A,B,C,D) of CLK_DIV clocks. A,B: SCL=0; C,D: SCL=1. The master changes its SDA at the start of A and samples SDA at the last clock of C.
- States (each lasts a whole number of bit periods):
  IDLE: SCL=1, SDA released.
  START (1 bit): SCL=1 all phases; SDA released in A,B; SDA=0 in C,D.
  ADDR (8 bits): shifts {addr,rw} MSB first.
  ADDR_ACK (1 bit): SDA released; sample. Sampled 0 -> WRITE if rw=0, READ if rw=1. Sampled 1 -> ack_err=1 -> STOP.
  WRITE (8 bits): shifts data_in MSB first.
  WRITE_ACK (1 bit): SDA released; sample. Sampled 1 sets ack_err=1. -> STOP.
  READ (8 bits): SDA released; shift sampled bits MSB first into a shift register.
  READ_ACK (1 bit): master drives NACK (SDA released). data_out is loaded from the shift register at the end of this bit, only when ack_err=0.
  STOP (1 bit): SDA=0 in A,B,C; SCL=0 in A,B and 1 in C,D; SDA released in D (rising SDA while SCL high). -> IDLE.
- done: one-clk pulse in the cycle IDLE is re-entered. busy falls in the same cycle.
- Latency from accept edge to done: full transaction 20 bits = 80*CLK_DIV clocks; address-NACK path 11 bits = 44*CLK_DIV clocks.
- A start held high continuously launches a new transaction on the first IDLE cycle after done. There is at least one IDLE cycle with SCL=1 and SDA released between transactions.
- ack_err holds its value until the next accepted start.
- Bit counter is 3 bits and wraps 0->7 on state entry. No X/Z may propagate into data_out: sampled z is treated as 1 via the bench pull-up.

Test Plan:
- Write 0x5A to addr 7'h2A (rw=0) with slave and SDA pull-up -> ack_err=0; slave captures 0x5A; done exactly 80*CLK_DIV clocks after accept; SCL/SDA idle high afterwards.
- Read from 7'h2A (rw=1) -> data_out=0xCC, ack_err=0, master NACK observed on the 9th data clock; STOP present.
- Address 7'h15 (no slave responds) -> ack_err=1, no data phase, STOP issued, done at 44*CLK_DIV clocks; data_out unchanged.
- start pulsed again mid-transfer, plus back-to-back start held high for two writes (0x11, 0x22) -> mid-transfer pulse ignored; two complete transactions with distinct STOP/START; slave sees 0x11 then 0x22.
- rst_n asserted during WRITE bit 3 -> same cycle: SCL=1, SDA=z, busy=0, ack_err=0; next write to 7'h2A after release completes normally.
- Protocol checker: SDA never changes while SCL=1 except at START (falling) and STOP (rising); SCL high/low widths each equal 2*CLK_DIV clocks.
